// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI-Stream FIFO.
package axis_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultDepth     = 16;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = (value > 0) ? value - 1 : 0; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Each word holds {tlast, tdata}. Contents are never reset.
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned DEPTH      = DefaultDepth
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [clog2(DEPTH)-1:0]  waddr_i,
    input  logic [DATA_WIDTH:0]      wdata_i,
    input  logic [clog2(DEPTH)-1:0]  raddr_i,
    output logic [DATA_WIDTH:0]      rdata_o
);

    logic [DATA_WIDTH:0] mem_q [DEPTH];

    // Write port: store the beat on an accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO with synchronous active-high reset.
// Optional packet mode, enabled by defining AXIS_FIFO_PACKET_MODE_EN, holds
// m_axis_tvalid low until a complete packet is stored or the FIFO is full.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned DEPTH      = DefaultDepth
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [clog2(DEPTH):0]    count
);

    localparam int unsigned PtrW = clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                wr_en, rd_en, full;
    logic [DATA_WIDTH:0] rd_word;

    assign full          = (count_q == CntFull);
    assign s_axis_tready = ~full;
    assign wr_en         = s_axis_tvalid & ~full;
    assign rd_en         = m_axis_tvalid & m_axis_tready;
    assign count         = count_q;
    assign m_axis_tdata  = rd_word[DATA_WIDTH-1:0];
    assign m_axis_tlast  = rd_word[DATA_WIDTH];

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Number of stored beats carrying tlast, i.e. complete packets queued.
    logic [CntW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic            pkt_in, pkt_out;

    assign pkt_in  = wr_en & s_axis_tlast;
    assign pkt_out = rd_en & m_axis_tlast;

    // Full release avoids deadlock on packets longer than the FIFO.
    assign m_axis_tvalid = (pkt_cnt_q != '0) | full;

    // Packet counter next state: hold when a packet enters and leaves together.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({pkt_in, pkt_out})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CntW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CntW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Packet counter register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`else
    assign m_axis_tvalid = (count_q != '0);
`endif

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    axis_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (aclk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({s_axis_tlast, s_axis_tdata}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_word)
    );

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_axis_fifo;

    localparam int unsigned DEPTH = 16;

    logic       aclk = 1'b0;
    logic       areset;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tlast;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tready;
    logic [4:0] count;

    int vectors     = 0;
    int miscompares = 0;
    int rx_count    = 0;
    int max_count   = 0;

    axis_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (DEPTH)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .count         (count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        bit         rst;
        bit         sv;
        logic [7:0] sd;
        bit         sl;
        bit         mr;
        int         exp_cnt;
        bit         exp_mv;
        logic [7:0] exp_md;
        bit         exp_ml;
        bit         exp_sr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: queue of stored beats {tlast, tdata}.
    logic [8:0] mq[$];

    function automatic bit model_valid();
        bit v;
`ifdef AXIS_FIFO_PACKET_MODE_EN
        v = (mq.size() == DEPTH);
        foreach (mq[i]) if (mq[i][8]) v = 1'b1;
`else
        v = (mq.size() != 0);
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit sv, input logic [7:0] sd, input bit sl,
                         input bit mr);
        areset        = rst;
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        s_axis_tlast  = sl;
        m_axis_tready = mr;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic add(input bit rst, input bit sv, input logic [7:0] sd, input bit sl,
                       input bit mr, input int ec, input bit emv, input logic [7:0] emd,
                       input bit eml, input bit esr);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.exp_cnt = ec; v.exp_mv = emv; v.exp_md = emd; v.exp_ml = eml; v.exp_sr = esr;
        vecs.push_back(v);
    endtask

    task automatic check_model(input string tag);
        bit ev;
        ev = model_valid();
        chk({tag, "_count"}, 32'(count), 32'(mq.size()));
        chk({tag, "_s_tready"}, 32'(s_axis_tready), 32'(mq.size() != DEPTH));
        chk({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'(ev));
        if (ev) begin
            chk({tag, "_m_tdata"}, 32'(m_axis_tdata), 32'(mq[0][7:0]));
            chk({tag, "_m_tlast"}, 32'(m_axis_tlast), 32'(mq[0][8]));
        end
        if (int'(count) > max_count) max_count = int'(count);
    endtask

    // One model-checked clock cycle; outputs depend only on registered state.
    task automatic cycle(input string tag, input bit rst, input bit sv, input logic [7:0] sd,
                         input bit sl, input bit mr, output bit accepted);
        bit wr, rd;
        drive(rst, sv, sd, sl, mr);
        check_model(tag);
        wr = sv && (mq.size() != DEPTH);
        rd = model_valid() && mr;
        tick();
        accepted = wr && !rst;
        if (rst) begin
            mq.delete();
        end else begin
            if (rd) begin
                void'(mq.pop_front());
                rx_count++;
            end
            if (wr) mq.push_back({sl, sd});
        end
    endtask

    initial begin
        bit acc;
        int sent;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

`ifndef AXIS_FIFO_PACKET_MODE_EN
        // Three beats streamed straight through, then reset mid-queue.
        add(1, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 1);
        add(0, 1, 8'h11, 0, 1,  1, 1, 8'h11, 0, 1);
        add(0, 1, 8'h22, 0, 1,  1, 1, 8'h22, 0, 1);
        add(0, 1, 8'h33, 1, 1,  1, 1, 8'h33, 1, 1);
        add(0, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) begin
            add(0, 1, 8'(8'h51 + i), 0, 0,  i + 1, 1, 8'h51, 0, 1);
        end
        add(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1);
        add(0, 1, 8'hA5, 0, 0,  1, 1, 8'hA5, 0, 1);
        add(0, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].mr);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_m_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].exp_mv));
            chk($sformatf("vec%0d_s_tready", i), 32'(s_axis_tready), 32'(vecs[i].exp_sr));
            if (vecs[i].exp_mv) begin
                chk($sformatf("vec%0d_m_tdata", i), 32'(m_axis_tdata), 32'(vecs[i].exp_md));
                chk($sformatf("vec%0d_m_tlast", i), 32'(m_axis_tlast), 32'(vecs[i].exp_ml));
            end
        end
`endif

        // Fill to DEPTH with the sink stalled, try an extra write, then one read.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_s_tready", 32'(s_axis_tready), 32'(0));
        chk("full_m_tvalid", 32'(m_axis_tvalid), 32'(1));
        chk("full_m_tdata", 32'(m_axis_tdata), 32'(8'h00));
        drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        tick();
        chk("full_nowrite_count", 32'(count), 32'(DEPTH));
        chk("full_stable_m_tdata", 32'(m_axis_tdata), 32'(8'h00));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        chk("release_s_tready", 32'(s_axis_tready), 32'(1));
        chk("release_count", 32'(count), 32'(DEPTH - 1));
`ifndef AXIS_FIFO_PACKET_MODE_EN
        chk("release_m_tdata", 32'(m_axis_tdata), 32'(8'h01));
`endif

`ifdef AXIS_FIFO_PACKET_MODE_EN
        // Packet gating: three beats stay hidden until the tlast beat lands.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        mq.delete();
        for (int i = 0; i < 3; i++) begin
            cycle("pkt_partial", 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, acc);
            chk("pkt_partial_hidden", 32'(m_axis_tvalid), 32'(0));
        end
        cycle("pkt_last", 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, acc);
        chk("pkt_released", 32'(m_axis_tvalid), 32'(1));
        // 20-beat packet: released only once the FIFO fills.
        cycle("pkt_rst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        for (int i = 0; i < DEPTH; i++) begin
            cycle("pkt_long", 1'b0, 1'b1, 8'(i), 1'b0, 1'b0, acc);
            chk("pkt_long_tvalid", 32'(m_axis_tvalid), 32'(i == DEPTH - 1));
        end
        sent = DEPTH;
        for (int c = 0; c < 100 && mq.size() != 0; c++) begin
            cycle("pkt_long_drain", 1'b0, sent < 20, 8'(sent), sent == 19, 1'b1, acc);
            if (acc) sent++;
        end
        chk("pkt_long_sent", 32'(sent), 32'(20));
`endif

        // 40 beats streamed across pointer wrap with tready toggling every 3 cycles.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        mq.delete();
        rx_count  = 0;
        max_count = 0;
        sent      = 0;
        for (int c = 0; c < 400 && rx_count < 40; c++) begin
            cycle("stream", 1'b0, sent < 40, 8'(sent), (sent % 8) == 7, ((c / 3) % 2) == 0,
                  acc);
            if (acc) sent++;
        end
        chk("stream_rx_beats", 32'(rx_count), 32'(40));
        chk("stream_max_count", 32'(max_count <= DEPTH), 32'(1));

        // Random traffic with occasional resets.
        for (int c = 0; c < 800; c++) begin
            cycle("rand", $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                  8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
